// File: rtl/mem_bus_responder_pkg.sv
// mem_bus_responder_pkg: shared FSM encoding, region decode constants and timeout read value
package mem_bus_responder_pkg;
  typedef enum logic [1:0] {S_IDLE, S_BRAM_RD, S_EXT_WAIT, S_DONE} state_e;
  typedef enum logic [1:0] {R_EXT, R_BRAM, R_UNMAPPED} region_e;
  localparam int EXT_SEL_BIT = 26;
  localparam logic [26:0] BRAM_BASE = 27'h4000000;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hFFFFFFFF;
endpackage

// File: rtl/mem_bus_bram.sv
// mem_bus_bram: single-port RAM, synchronous write, registered read
// Ports: clk; we_i/addr_i/wdata_i write or read request; rdata_o word at addr_i one cycle later.
module mem_bus_bram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= wdata_i;
    rdata_o <= mem[addr_i];
  end
endmodule

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: CPU memory-bus responder routing requests to internal BRAM or an external slow device
// Ports: clk; reset (async, active-low); start/we/address/data CPU request; q read data; busy CPU stall;
//        ext_req/ext_we/ext_addr/ext_wdata external request; ext_ack/ext_rdata external completion;
//        bus_err sticky external-timeout flag.
// Option: define MEM_BUS_TIMEOUT_EN to abort external accesses after TIMEOUT_CYCLES wait cycles.
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int BRAM_AW        = 10,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        we,
  input  logic [26:0] address,
  input  logic [31:0] data,
  output logic [31:0] q,
  output logic        busy,
  output logic        ext_req,
  output logic        ext_we,
  output logic [25:0] ext_addr,
  output logic [31:0] ext_wdata,
  input  logic        ext_ack,
  input  logic [31:0] ext_rdata,
  output logic        bus_err
);
  state_e state_q, state_d;
  region_e region;
  logic [25:0] addr_q;
  logic we_q;
  logic [31:0] data_q, q_q, q_d, ram_rdata;
  logic accept, ram_we, timeout;
  logic [BRAM_AW-1:0] ram_addr;
  assign accept = state_q == S_IDLE && start;
  assign region = !address[EXT_SEL_BIT] ? R_EXT :
                  (address >> BRAM_AW) == (BRAM_BASE >> BRAM_AW) ? R_BRAM : R_UNMAPPED;
  assign ram_we = accept && region == R_BRAM && we;
  // the RAM sees the live address in the accept cycle so read data is ready on entry to BRAM_RD
  assign ram_addr = state_q == S_IDLE ? address[BRAM_AW-1:0] : addr_q[BRAM_AW-1:0];
  mem_bus_bram #(.AW(BRAM_AW)) u_bram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (data),
    .rdata_o (ram_rdata)
  );
`ifdef MEM_BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic err_q;
  // an ack arriving in the final wait cycle still wins over the timeout
  assign timeout = state_q == S_EXT_WAIT && !ext_ack && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= state_q == S_EXT_WAIT ? cnt_q + 1'b1 : '0;
      err_q <= err_q | timeout;
    end
  end
  assign bus_err = err_q;
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    q_d = q_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = region == R_EXT ? S_EXT_WAIT : region == R_BRAM && !we ? S_BRAM_RD : S_DONE;
        if (region == R_UNMAPPED && !we) q_d = '0;
      end
      S_BRAM_RD: begin
        state_d = S_DONE;
        q_d = ram_rdata;
      end
      S_EXT_WAIT: if (ext_ack || timeout) begin
        state_d = S_DONE;
        if (!we_q) q_d = ext_ack ? ext_rdata : TIMEOUT_RDATA;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      q_q <= '0;
      addr_q <= '0;
      we_q <= 1'b0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      q_q <= q_d;
      if (accept) begin
        addr_q <= address[25:0];
        we_q <= we;
        data_q <= data;
      end
    end
  end
  // gating with reset keeps busy low while reset is held, even if the CPU holds start
  assign busy = reset && (state_q == S_IDLE ? start : state_q != S_DONE);
  assign ext_req = state_q == S_EXT_WAIT;
  assign ext_we = we_q;
  assign ext_addr = addr_q;
  assign ext_wdata = data_q;
  assign q = q_q;
endmodule

// File: tb/tb_mem_bus_responder.sv
// tb_mem_bus_responder: table-driven scoreboard bench for mem_bus_responder
module tb_mem_bus_responder;
`ifdef MEM_BUS_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif
  typedef struct {int lat; logic [31:0] q; int nreq;} exp_t;
  typedef struct {logic w; logic [26:0] a; logic [31:0] d; int ack; logic [31:0] rd; int lat; logic [31:0] q;} vec_t;
  logic clk = 0, reset = 0, start = 0, we = 0, ext_ack = 0;
  logic [26:0] address = '0;
  logic [31:0] data = '0, ext_rdata = '0;
  logic [31:0] q, ext_wdata;
  logic busy, ext_req, ext_we, bus_err;
  logic [25:0] ext_addr;
  int total = 0, bad = 0;
  exp_t sb[$];
  vec_t vt[12];
  always #5 clk = ~clk;
  mem_bus_responder #(.BRAM_AW(10), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .we(we), .address(address), .data(data),
    .q(q), .busy(busy), .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_ack(ext_ack), .ext_rdata(ext_rdata), .bus_err(bus_err)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic idle();
    @(posedge clk); #1;
    start = 0;
  endtask
  task automatic access(input logic w, input logic [26:0] a, input logic [31:0] d,
                        input int ack_lat, input logic [31:0] rd, input exp_t e);
    int lat, nreq;
    logic ok;
    exp_t x;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1; we = w; address = a; data = d;
    @(negedge clk);
    chk("busy_on_start", busy, 1);
    lat = 0; nreq = 0; ok = 1;
    while (lat < 40) begin
      @(posedge clk); #1;
      ext_ack = 0;
      lat++;
      if (lat == 1) begin
        we = ~w; address = 27'($urandom); data = $urandom;
      end
      @(negedge clk);
      if (!busy) break;
      if (ext_req) begin
        nreq++;
        if (ext_addr !== a[25:0] || ext_we !== w || ext_wdata !== d) ok = 0;
        if (nreq == ack_lat) begin
          ext_ack = 1; ext_rdata = rd;
        end
      end
    end
    if (lat >= 40) $display("FAIL done_wait: busy still %b after %0d cycles", busy, lat);
    x = sb.pop_front();
    chk("latency", lat, x.lat);
    chk("q", q, x.q);
    chk("ext_req_cycles", nreq, x.nreq);
    if (nreq > 0) chk("ext_fields_stable", ok, 1);
  endtask
  initial begin
    logic seen;
    vt = '{
      '{1'b1, 27'h4000010, 32'hCAFEBABE, 0, 32'h0,        1, 32'h00000000},
      '{1'b0, 27'h4000010, 32'h0,        0, 32'h0,        2, 32'hCAFEBABE},
      '{1'b0, 27'h0001234, 32'h0,        5, 32'h12345678, 6, 32'h12345678},
      '{1'b0, 27'h4000400, 32'h0,        0, 32'h0,        1, 32'h00000000},
      '{1'b1, 27'h4000000, 32'h11111111, 0, 32'h0,        1, 32'h00000000},
      '{1'b1, 27'h4000400, 32'hDEADBEEF, 0, 32'h0,        1, 32'h00000000},
      '{1'b0, 27'h4000000, 32'h0,        0, 32'h0,        2, 32'h11111111},
      '{1'b1, 27'h0000008, 32'h55AA55AA, 2, 32'h99999999, 3, 32'h11111111},
      '{1'b1, 27'h40003FF, 32'hA5A5A5A5, 0, 32'h0,        1, 32'h11111111},
      '{1'b0, 27'h40003FF, 32'h0,        0, 32'h0,        2, 32'hA5A5A5A5},
      '{1'b0, 27'h3FFFFFF, 32'h0,        1, 32'h0BADF00D, 2, 32'h0BADF00D},
      '{1'b0, 27'h7FFFFFF, 32'h0,        0, 32'h0,        1, 32'h00000000}
    };
    start = 1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_q", q, 0);
    chk("rst_ext_req", ext_req, 0);
    chk("rst_bus_err", bus_err, 0);
    @(posedge clk); #1;
    start = 0; reset = 1;
    for (int i = 0; i < 12; i++) begin
      access(vt[i].w, vt[i].a, vt[i].d, vt[i].ack, vt[i].rd, '{vt[i].lat, vt[i].q, vt[i].ack});
      idle();
    end
    access(1'b0, 27'h4000000, 32'h0, 0, 32'h0, '{2, 32'h11111111, 0});
    access(1'b1, 27'h0000008, 32'h77777777, 3, 32'h0, '{4, 32'h11111111, 3});
    idle();
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | busy | ext_req;
    end
    chk("no_duplicate", seen, 0);
    access(1'b0, 27'h40003FF, 32'h0, 0, 32'h0, '{2, 32'hA5A5A5A5, 0});
    idle();
    @(posedge clk); #1;
    start = 1; we = 0; address = 27'h0000100;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_ext_req", ext_req, 1);
    #2 reset = 0;
    #1;
    chk("rst_abandon_ext_req", ext_req, 0);
    chk("rst_abandon_busy", busy, 0);
    chk("rst_abandon_q", q, 0);
    @(posedge clk); #1;
    start = 0; reset = 1; ext_ack = 1; ext_rdata = 32'hFFFF0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("late_ack_q", q, 0);
    chk("late_ack_busy", busy, 0);
    chk("late_ack_ext_req", ext_req, 0);
    ext_ack = 0;
    access(1'b0, 27'h40003FF, 32'h0, 0, 32'h0, '{2, 32'hA5A5A5A5, 0});
    idle();
`ifdef MEM_BUS_TIMEOUT_EN
    access(1'b0, 27'h0000040, 32'h0, 0, 32'h0, '{TO + 1, 32'hFFFFFFFF, TO});
    idle();
    @(negedge clk);
    chk("bus_err_set", bus_err, 1);
    access(1'b0, 27'h4000010, 32'h0, 0, 32'h0, '{2, 32'hCAFEBABE, 0});
    idle();
    @(negedge clk);
    chk("bus_err_sticky", bus_err, 1);
    @(posedge clk); #1;
    reset = 0;
    #2;
    chk("bus_err_cleared", bus_err, 0);
    reset = 1;
`else
    @(negedge clk);
    chk("bus_err_tied", bus_err, 0);
`endif
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
